// File: rtl/sync_down_timer.sv
// rtl/sync_down_timer.sv - loadable T-flip-flop down-counter with one-shot/auto-reload terminal count
module sync_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] dec_t;
    logic             borrow;
    logic             step;
    logic             at_one;
    logic             tc_nxt;

    assign zero   = (count == '0);
    assign at_one = (count == ONE);
    assign step   = (state == RUN) && en;

    // Decrement toggles: bit i flips when every lower bit is zero (borrow ripples up).
    always_comb begin
        dec_t  = '0;
        borrow = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            dec_t[i] = borrow;
            borrow   = borrow & ~count[i];
        end
    end

    always_comb begin
        t = '0;
        if (load) begin
            t = count ^ load_val;
        end else if (step) begin
            if (zero) begin
                if (mode) begin
                    t = count ^ reload_reg;
                end
            end else begin
                t = dec_t;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = (load_val != '0) ? RUN : IDLE;
        end else if (step && (at_one || zero) && !mode) begin
            state_nxt = IDLE;
        end
    end

    assign tc_nxt = !load && step && at_one;

    // Count bits only ever toggle; there is no direct data path into them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count ^ t;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            reload_reg <= '0;
            tc         <= 1'b0;
            running    <= 1'b0;
        end else begin
            state   <= state_nxt;
            tc      <= tc_nxt;
            running <= (state_nxt == RUN);
            if (load) begin
                reload_reg <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_sync_down_timer.sv
// tb/tb_sync_down_timer.sv - randomized and directed self-checking bench for sync_down_timer
module tb_sync_down_timer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc;
    logic             running;

    int errors = 0;
    int checks = 0;

    int m_cnt  = 0;
    int m_rel  = 0;
    int m_run  = 0;
    int m_tc   = 0;

    sync_down_timer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .mode     (mode),
        .count    (count),
        .zero     (zero),
        .tc       (tc),
        .running  (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour in plain integer arithmetic, one call per rising edge.
    task automatic model_update();
        if (!rst) begin
            m_cnt = 0; m_rel = 0; m_run = 0; m_tc = 0;
        end else if (load) begin
            m_cnt = int'(load_val);
            m_rel = int'(load_val);
            m_tc  = 0;
            m_run = (load_val != 0) ? 1 : 0;
        end else if (m_run != 0 && en) begin
            if (m_cnt > 1) begin
                m_cnt = m_cnt - 1;
                m_tc  = 0;
            end else if (m_cnt == 1) begin
                m_cnt = 0;
                m_tc  = 1;
                m_run = mode ? 1 : 0;
            end else begin
                m_tc = 0;
                if (mode) m_cnt = m_rel;
                else      m_run = 0;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check("count",   int'(count),   m_cnt);
        check("zero",    int'(zero),    (m_cnt == 0) ? 1 : 0);
        check("tc",      int'(tc),      m_tc);
        check("running", int'(running), m_run);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = WIDTH'(v);
        tick();
        load = 1'b0;
    endtask

    int exp_os [8] = '{5, 4, 3, 2, 1, 0, 0, 0};
    int exp_ar [9] = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
    int en_pat [6] = '{1, 0, 0, 1, 1, 1};
    int exp_st [6] = '{3, 3, 3, 2, 1, 0};
    int last_tc;

    initial begin
        rst = 1'b0; load = 1'b1; load_val = 4'd9; en = 1'b1; mode = 1'b0;
        #1;

        // Reset priority over a simultaneous load
        tick();
        tick();
        check("rst_count", int'(count), 0);
        check("rst_zero",  int'(zero), 1);
        check("rst_run",   int'(running), 0);
        rst = 1'b1; load = 1'b0;
        tick();
        check("post_rst_count", int'(count), 0);

        // One-shot from 5
        mode = 1'b0; en = 1'b1;
        load = 1'b1; load_val = 4'd5;
        for (int i = 0; i < 8; i++) begin
            tick();
            load = 1'b0;
            check("os_seq", int'(count), exp_os[i]);
            check("os_tc",  int'(tc), (i == 5) ? 1 : 0);
            check("os_run", int'(running), (i < 5) ? 1 : 0);
        end

        // Auto-reload from 3: tc every 4 cycles
        mode = 1'b1;
        load = 1'b1; load_val = 4'd3;
        last_tc = -1;
        for (int i = 0; i < 9; i++) begin
            tick();
            load = 1'b0;
            check("ar_seq", int'(count), exp_ar[i]);
            check("ar_run", int'(running), 1);
            if (tc) begin
                if (last_tc >= 0) check("ar_period", i - last_tc, 4);
                last_tc = i;
            end
        end

        // Enable stalls from 4
        mode = 1'b0;
        do_load(4);
        check("st_load", int'(count), 4);
        for (int i = 0; i < 6; i++) begin
            en = en_pat[i][0];
            tick();
            check("st_seq", int'(count), exp_st[i]);
            check("st_tc",  int'(tc), (i == 5) ? 1 : 0);
        end
        en = 1'b1;
        do_load(2);
        tick();
        en = 1'b0;
        tick();
        tick();
        check("st_hold1", int'(count), 1);
        check("st_hold_tc", int'(tc), 0);
        en = 1'b1;

        // Mid-run load, zero load, reset
        do_load(5);
        tick(); tick(); tick();
        check("mr_at2", int'(count), 2);
        do_load(9);
        check("mr_load9", int'(count), 9);
        check("mr_load9_tc", int'(tc), 0);
        do_load(0);
        check("mr_load0", int'(count), 0);
        check("mr_load0_run", int'(running), 0);
        do_load(8);
        tick(); tick();
        check("mr_at6", int'(count), 6);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mr_rst", int'(count), 0);
        check("mr_rst_run", int'(running), 0);

        // mode 1 -> 0 while sitting at zero in RUN
        mode = 1'b1;
        do_load(2);
        tick(); tick();
        check("mz_at0", int'(count), 0);
        mode = 1'b0;
        tick();
        check("mz_count", int'(count), 0);
        check("mz_run", int'(running), 0);
        check("mz_tc", int'(tc), 0);

        // Full range, 16-cycle period with every toggle pattern
        mode = 1'b1;
        do_load(15);
        for (int i = 1; i <= 17; i++) begin
            tick();
            check("fr_seq", int'(count), (i == 16) ? 15 : ((i == 17) ? 14 : 15 - i));
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 99) != 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
